// File: rtl/lcd_pkg.sv
// Shared types and constants for the DE2 character-LCD write controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP = 3'd0,
    LOAD  = 3'd1,
    IDLE  = 3'd2,
    SETUP = 3'd3,
    PULSE = 3'd4,
    HOLD  = 3'd5,
    WAIT  = 3'd6
  } lcd_state_t;

  // Function set 8-bit/2-line, display on, clear, entry mode increment
  localparam logic [7:0] LCD_INIT [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  localparam int ST_BUSY = 0;
  localparam int ST_INIT = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_PEND = 3;

  localparam int IO_ON      = 31;
  localparam int IO_OVF_CLR = 11;
  localparam int IO_REQ     = 10;
  localparam int IO_RS      = 9;
  localparam int IO_DATA_HI = 7;
  localparam int IO_DATA_LO = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear and return-home commands need the long post-write wait
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// HD44780 8-bit write controller: power-up init sequence, then software
// requests via a toggle handshake with a one-deep pending slot.
module lcd_ctrl import lcd_pkg::*; #(
  parameter int T_POWERUP = 750000,
  parameter int T_SETUP   = 2,
  parameter int T_EN      = 12,
  parameter int T_HOLD    = 2,
  parameter int T_CMD     = 2000,
  parameter int T_CLEAR   = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_lcd,
  output logic        lcd_on,
  output logic        lcd_en,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic [7:0]  lcd_data,
  output logic [31:0] lcd_status
);

  localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_EN, T_HOLD)),
                              max2(T_CMD, T_CLEAR));
  localparam int CW = (T_MAX > 2) ? $clog2(T_MAX) : 1;

  lcd_state_t    state_r, state_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic          tog_r;
  logic          pending_r, pend_rs_r;
  logic [7:0]    pend_data_r;
  logic          overflow_r, init_done_r, busy_r;
  logic [1:0]    init_idx_r;
  logic          lcd_en_r, lcd_rs_r, lcd_on_r;
  logic [7:0]    lcd_data_r;

  logic          req_s, capture_s, ovf_set_s, cnt_zero_s;
  logic          send_s, consume_s, init_step_s, send_rs_s;
  logic [7:0]    send_data_s;
  logic          unused_s;

  assign unused_s   = ^{io_lcd[30:12], io_lcd[8]};
  assign cnt_zero_s = (cnt_r == {CW{1'b0}});

  // Request edge detect and pending-slot arbitration
  always_comb begin
    req_s     = io_lcd[IO_REQ] ^ tog_r;
    capture_s = req_s & (~pending_r | consume_s);
    ovf_set_s = req_s & pending_r & ~consume_s;
  end

  // Next-state, counter reload and transfer selection
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_zero_s ? cnt_r : (cnt_r - CW'(1));
    send_s      = 1'b0;
    consume_s   = 1'b0;
    init_step_s = 1'b0;
    send_rs_s   = 1'b0;
    send_data_s = 8'h00;
    case (state_r)
      PWRUP: begin
        if (cnt_zero_s) state_n = LOAD;
        else            state_n = PWRUP;
      end
      LOAD: begin
        if (!init_done_r) begin
          send_s      = 1'b1;
          send_rs_s   = 1'b0;
          send_data_s = LCD_INIT[init_idx_r];
        end else if (pending_r) begin
          send_s      = 1'b1;
          consume_s   = 1'b1;
          send_rs_s   = pend_rs_r;
          send_data_s = pend_data_r;
        end else begin
          state_n = IDLE;
        end
        if (send_s) begin
          state_n = SETUP;
          cnt_n   = CW'(T_SETUP - 1);
        end else begin
          cnt_n = cnt_r;
        end
      end
      IDLE: begin
        if (pending_r) state_n = LOAD;
        else           state_n = IDLE;
      end
      SETUP: begin
        if (cnt_zero_s) begin
          state_n = PULSE;
          cnt_n   = CW'(T_EN - 1);
        end else begin
          state_n = SETUP;
        end
      end
      PULSE: begin
        if (cnt_zero_s) begin
          state_n = HOLD;
          cnt_n   = CW'(T_HOLD - 1);
        end else begin
          state_n = PULSE;
        end
      end
      HOLD: begin
        if (cnt_zero_s) begin
          state_n = WAIT;
          cnt_n   = is_slow_cmd(lcd_rs_r, lcd_data_r) ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
        end else begin
          state_n = HOLD;
        end
      end
      WAIT: begin
        if (cnt_zero_s) begin
          state_n     = LOAD;
          init_step_s = ~init_done_r;
        end else begin
          state_n = WAIT;
        end
      end
      default: begin
        state_n = PWRUP;
        cnt_n   = CW'(T_POWERUP - 1);
      end
    endcase
  end

  // FSM, counter, init progress and registered LCD pins
  always_ff @(posedge clk) begin
    tog_r <= io_lcd[IO_REQ];
    if (rst) begin
      state_r     <= PWRUP;
      cnt_r       <= CW'(T_POWERUP - 1);
      init_done_r <= 1'b0;
      init_idx_r  <= 2'd0;
      busy_r      <= 1'b1;
      lcd_en_r    <= 1'b0;
      lcd_rs_r    <= 1'b0;
      lcd_data_r  <= 8'h00;
      lcd_on_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      busy_r   <= (state_n != IDLE);
      lcd_en_r <= (state_n == PULSE);
      lcd_on_r <= io_lcd[IO_ON];
      if (send_s) begin
        lcd_rs_r   <= send_rs_s;
        lcd_data_r <= send_data_s;
      end
      if (init_step_s) begin
        if (init_idx_r == 2'd3) init_done_r <= 1'b1;
        else                    init_idx_r  <= init_idx_r + 2'd1;
      end
    end
  end

  // One-deep pending buffer and sticky overflow (set beats clear)
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_r   <= 1'b0;
      pend_rs_r   <= 1'b0;
      pend_data_r <= 8'h00;
      overflow_r  <= 1'b0;
    end else begin
      if (capture_s) begin
        pending_r   <= 1'b1;
        pend_rs_r   <= io_lcd[IO_RS];
        pend_data_r <= io_lcd[IO_DATA_HI:IO_DATA_LO];
      end else if (consume_s) begin
        pending_r <= 1'b0;
      end
      if (ovf_set_s)               overflow_r <= 1'b1;
      else if (io_lcd[IO_OVF_CLR]) overflow_r <= 1'b0;
    end
  end

  // Status word assembled from flops only
  always_comb begin
    lcd_status          = 32'd0;
    lcd_status[ST_BUSY] = busy_r;
    lcd_status[ST_INIT] = init_done_r;
    lcd_status[ST_OVF]  = overflow_r;
    lcd_status[ST_PEND] = pending_r;
  end

  assign lcd_on   = lcd_on_r;
  assign lcd_en   = lcd_en_r;
  assign lcd_rs   = lcd_rs_r;
  assign lcd_rw   = 1'b0;
  assign lcd_data = lcd_data_r;

endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
Downstream consumer of the core's memory-mapped LCD output word (io_LCD from the LSU). It turns register writes into correctly timed write cycles on the HD44780-style 8-bit character LCD of the DE2 board. On power-up it runs the controller init sequence, then serves software requests through a toggle handshake with a one-deep pending buffer. A status word is returned for the LSU read path.

Parameters:
T_POWERUP, 750000, cycles to wait after reset before the first init command (15 ms @ 50 MHz)
T_SETUP, 2, cycles RS/DATA are stable before EN rises
T_EN, 12, cycles EN is held high
T_HOLD, 2, cycles RS/DATA are held after EN falls
T_CMD, 2000, post-write wait for normal commands and data (40 us)
T_CLEAR, 82000, post-write wait for clear/home commands (1.64 ms)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
io_lcd  in  32  LSU LCD register: [31]=ON, [11]=clear overflow (level), [10]=request toggle, [9]=RS, [7:0]=DATA
lcd_on  out  1  display power, registered copy of io_lcd[31]
lcd_en  out  1  LCD enable strobe
lcd_rs  out  1  register select (0 = command, 1 = data)
lcd_rw  out  1  read/write select, constant 0 (write-only)
lcd_data  out  8  LCD data bus
lcd_status  out  32  [0]=busy, [1]=init_done, [2]=overflow (sticky), [3]=pending; [31:4]=0

Behaviour:
- Reset (synchronous, active-high):
  - lcd_en, lcd_rs, lcd_rw, lcd_data and lcd_on are 0.
  - State is PWRUP and the counter is loaded with T_POWERUP-1.
  - pending=0, overflow=0, init_done=0, init index=0.
  - tog_q is loaded with io_lcd[10], so a level already present at reset is not a request.
- Request detect: req = io_lcd[10] ^ tog_q. tog_q <= io_lcd[10] every cycle.
- Pending capture:
  - When req is seen and pending=0, capture {RS=io_lcd[9], DATA=io_lcd[7:0]} and set pending=1.
  - When req is seen and pending=1, drop the request and set overflow=1.
- Overflow clears while io_lcd[11]=1. If a set and a clear happen in the same cycle, the set wins.
- One down-counter (width = clog2 of the largest parameter). A phase ends on the cycle the counter is 0; the next phase's count-1 is loaded at that point.
- FSM states:
  - PWRUP: wait T_POWERUP, then go to LOAD with the source set to init.
  - LOAD: select the transfer.
    - If init is not done: send ROM entry init index. The ROM is 0x38, 0x0C, 0x01, 0x06, all with RS=0.
    - Else if pending=1: send the pending entry and clear pending in this same cycle. A capture in this same cycle is accepted into the freed slot.
    - Else: go to IDLE.
    - On a send: drive lcd_rs and lcd_data, then go to SETUP.
  - IDLE: go to LOAD on the cycle after pending becomes 1.
  - SETUP: lasts T_SETUP cycles, lcd_en=0. Then PULSE.
  - PULSE: lasts T_EN cycles, lcd_en=1. Then HOLD.
  - HOLD: lasts T_HOLD cycles, lcd_en=0, RS/DATA held. Then WAIT.
  - WAIT:
    - The wait is T_CLEAR when RS=0 and DATA is 0x01, 0x02 or 0x03; otherwise it is T_CMD.
    - At the end of WAIT during init, increment init index. After index 3, set init_done=1.
    - Then go to LOAD.
- lcd_rs and lcd_data change only in LOAD. They hold their value through IDLE.
- busy=1 in every state except IDLE. During init, busy=1 and init_done=0.
- Requests during PWRUP or init are captured into pending and served immediately after init.
- Latency from toggle to EN rising, starting from IDLE: toggle sampled at edge k, pending=1 after k, LOAD at k+1, SETUP begins at k+2, lcd_en=1 from k+2+T_SETUP.
- lcd_on <= io_lcd[31] every cycle. It is independent of the FSM.
- lcd_rw is always 0.
- Reset mid-transfer aborts immediately. lcd_en is 0 on the next cycle and the full power-up and init sequence restarts.

Decomposition:
- Shared package lcd_pkg:
  - state enum lcd_state_t: PWRUP, LOAD, IDLE, SETUP, PULSE, HOLD, WAIT
  - init ROM constant array LCD_INIT[4]
  - status bit indices ST_BUSY, ST_INIT, ST_OVF, ST_PEND
  - io_lcd bit indices
- No sub-module. The counter, FSM and pending buffer stay in lcd_ctrl.

Test Plan:
All scenarios use small parameters: T_POWERUP=10, T_SETUP=2, T_EN=3, T_HOLD=1, T_CMD=5, T_CLEAR=20.
- Reset release:
  - During PWRUP, busy=1 and lcd_en=0 for 10 cycles.
  - Then exactly 4 EN pulses of 3 cycles each with RS=0, DATA 0x38, 0x0C, 0x01, 0x06.
  - The gap after 0x01 is 20 wait cycles; the other gaps are 5.
  - init_done=1 and busy=0 afterwards.
- After init, toggle io_lcd[10] with RS=1, DATA=0x41:
  - lcd_en rises exactly 4 cycles after the sampling edge and stays high 3 cycles with rs=1, data=0x41.
  - busy returns to 0 after 2+3+1+5 cycles.
- Mid-transfer toggles:
  - Toggle once mid-transfer with DATA=0x42: it is served right after the current WAIT.
  - Toggle twice more while pending: overflow=1 and only one extra pulse occurs.
  - Then io_lcd[11]=1: overflow=0.
- Toggle 3 cycles after reset (during PWRUP) with DATA=0x48:
  - The pulse for 0x48 occurs after the 4th init command; pending=1 until then.
- Assert rst during PULSE:
  - lcd_en=0 on the next cycle and lcd_data=0.
  - The PWRUP count restarts and the init sequence repeats in full.
- Hold io_lcd[10]=1 through reset:
  - No request is generated after reset release.
  - lcd_on tracks io_lcd[31] with 1-cycle latency.
